// File: rtl/weight_ctrl_pkg.sv
// Shared types for the weight-load controller: FSM states, beat type, owner encoding.
// The owner value doubles as the bit index into the two-bit request/flag vectors.
package weight_ctrl_pkg;

    localparam int BEAT_BYTES = 64;

    typedef logic [63:0][7:0] weight_beat_t;

    typedef enum logic {
        OWN_RDN = 1'b0,
        OWN_DNN = 1'b1
    } owner_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_ARB,
        S_MEM,
        S_RESP,
        S_DONE
    } wlc_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. On a tie it grants the requester that was not served last;
// the last-owner pointer only moves when the parent reports a completed beat.
module rr_arb2 import weight_ctrl_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_owner,
    output logic       gnt_vld,
    output logic       gnt_owner
);

    logic last;

    // Pointer resets to DNN so the first tie goes to RDN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= OWN_DNN;
        end else if (update) begin
            last <= upd_owner;
        end
    end

    always_comb begin
        gnt_vld   = |req;
        gnt_owner = OWN_RDN;
        if (req == 2'b11) begin
            gnt_owner = (last == OWN_RDN) ? OWN_DNN : OWN_RDN;
        end else if (req[OWN_DNN]) begin
            gnt_owner = OWN_DNN;
        end
    end

endmodule

// File: rtl/weight_load_ctrl.sv
// Kicks RDN and DNN weight loading, shares the single 512-bit weight-memory read port
// between them round-robin, and pulses done once both stages hold a full weight set.
module weight_load_ctrl import weight_ctrl_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] rdn_base,
    input  logic [ADDR_W-1:0] dnn_base,
    output logic              rdn_load_weights,
    output logic              dnn_load_weights,
    input  logic              rdn_mem_req,
    input  logic              dnn_mem_req,
    input  logic              rdn_weights_vld,
    input  logic              dnn_weights_vld,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ready,
    input  logic [63:0][7:0]  mem_rd_data,
    output logic              rdn_mem_ready,
    output logic              dnn_mem_ready,
    output logic [63:0][7:0]  rdn_weight_data,
    output logic [63:0][7:0]  dnn_weight_data,
    output logic              busy,
    output logic              done
);

    wlc_state_e        state, state_d;
    logic [ADDR_W-1:0] rdn_base_q, dnn_base_q, grant_addr;
    logic [CNT_W-1:0]  rdn_cnt, dnn_cnt;
    logic [1:0]        flag, vld_eff, eligible;
    logic              owner, arb_vld, arb_owner, grant, all_vld, resp_now;

    // A weights_vld seen this cycle counts as already flagged, so it beats a same-cycle grant.
    assign vld_eff  = flag | {dnn_weights_vld, rdn_weights_vld};
    assign all_vld  = &vld_eff;
    assign eligible = {dnn_mem_req, rdn_mem_req} & ~vld_eff;
    assign resp_now = (state == S_RESP);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (eligible),
        .update    (resp_now),
        .upd_owner (owner),
        .gnt_vld   (arb_vld),
        .gnt_owner (arb_owner)
    );

    always_comb begin
        if (arb_owner == OWN_DNN) begin
            grant_addr = dnn_base_q + ADDR_W'(dnn_cnt) * ADDR_W'(BEAT_BYTES);
        end else begin
            grant_addr = rdn_base_q + ADDR_W'(rdn_cnt) * ADDR_W'(BEAT_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        grant   = 1'b0;
        case (state)
            S_IDLE: if (start) state_d = S_KICK;
            S_KICK: state_d = S_ARB;
            S_ARB: begin
                if (all_vld) begin
                    state_d = S_DONE;
                end else if (arb_vld) begin
                    grant   = 1'b1;
                    state_d = S_MEM;
                end
            end
            S_MEM:  if (mem_rd_ready) state_d = S_RESP;
            S_RESP: state_d = S_ARB;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdn_load_weights <= 1'b0;
            dnn_load_weights <= 1'b0;
            mem_rd_req       <= 1'b0;
            mem_rd_addr      <= '0;
            rdn_mem_ready    <= 1'b0;
            dnn_mem_ready    <= 1'b0;
            rdn_weight_data  <= '0;
            dnn_weight_data  <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            rdn_base_q       <= '0;
            dnn_base_q       <= '0;
            rdn_cnt          <= '0;
            dnn_cnt          <= '0;
            flag             <= '0;
            owner            <= OWN_RDN;
        end else begin
            rdn_load_weights <= 1'b0;
            dnn_load_weights <= 1'b0;
            rdn_mem_ready    <= 1'b0;
            dnn_mem_ready    <= 1'b0;
            done             <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rdn_base_q       <= rdn_base;
                        dnn_base_q       <= dnn_base;
                        busy             <= 1'b1;
                        rdn_load_weights <= 1'b1;
                        dnn_load_weights <= 1'b1;
                    end
                end
                S_KICK: begin
                    rdn_cnt <= '0;
                    dnn_cnt <= '0;
                    flag    <= '0;
                end
                S_ARB: begin
                    flag <= vld_eff;
                    if (all_vld) begin
                        done <= 1'b1;
                    end else if (grant) begin
                        owner       <= arb_owner;
                        mem_rd_req  <= 1'b1;
                        mem_rd_addr <= grant_addr;
                    end
                end
                S_MEM: begin
                    flag <= vld_eff;
                    if (mem_rd_ready) begin
                        mem_rd_req <= 1'b0;
                        if (owner == OWN_DNN) begin
                            dnn_weight_data <= mem_rd_data;
                            dnn_mem_ready   <= 1'b1;
                        end else begin
                            rdn_weight_data <= mem_rd_data;
                            rdn_mem_ready   <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    flag <= vld_eff;
                    if (owner == OWN_DNN) begin
                        dnn_cnt <= dnn_cnt + CNT_W'(1);
                    end else begin
                        rdn_cnt <= rdn_cnt + CNT_W'(1);
                    end
                end
                S_DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench: behavioural requesters and memory, expected beats queued per test,
// and a monitor that pops and compares whenever a stage receives a beat.
module tb_weight_load_ctrl;
    import weight_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       rdn_base = '0, dnn_base = '0;
    logic              rdn_load_weights, dnn_load_weights;
    logic              rdn_mem_req = 1'b0, dnn_mem_req = 1'b0;
    logic              rdn_weights_vld = 1'b0, dnn_weights_vld = 1'b0;
    logic              mem_rd_req;
    logic [31:0]       mem_rd_addr;
    logic              mem_rd_ready = 1'b0;
    logic [63:0][7:0]  mem_rd_data = '0;
    logic              rdn_mem_ready, dnn_mem_ready;
    logic [63:0][7:0]  rdn_weight_data, dnn_weight_data;
    logic              busy, done;

    int           n_checks = 0, n_errors = 0;
    logic [32:0]  exp_q[$];
    weight_beat_t shadow_rdn = '0, shadow_dnn = '0;
    int           rdn_left = 0, dnn_left = 0, rdn_served = 0, dnn_served = 0;
    int           rdn_vld_at = -1, dnn_vld_at = -1;
    int           mem_delay = 0, mem_wait = 0;
    bit           a5_mode = 1'b0;
    logic [31:0]  cap_addr = '0, prev_addr = '0;
    logic         prev_req = 1'b0;
    int           req_len = 0, last_req_len = 0, req_cycles = 0;

    weight_load_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .rdn_base         (rdn_base),
        .dnn_base         (dnn_base),
        .rdn_load_weights (rdn_load_weights),
        .dnn_load_weights (dnn_load_weights),
        .rdn_mem_req      (rdn_mem_req),
        .dnn_mem_req      (dnn_mem_req),
        .rdn_weights_vld  (rdn_weights_vld),
        .dnn_weights_vld  (dnn_weights_vld),
        .mem_rd_req       (mem_rd_req),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_ready     (mem_rd_ready),
        .mem_rd_data      (mem_rd_data),
        .rdn_mem_ready    (rdn_mem_ready),
        .dnn_mem_ready    (dnn_mem_ready),
        .rdn_weight_data  (rdn_weight_data),
        .dnn_weight_data  (dnn_weight_data),
        .busy             (busy),
        .done             (done)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic weight_beat_t beat_of(input logic [31:0] a);
        if (a5_mode) return {64{8'hA5}};
        return {16{a}};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requesters: hold req while beats remain, raise weights_vld after a chosen beat count.
    initial begin
        forever begin
            @(negedge clk);
            if (rdn_mem_ready && rdn_left > 0) begin
                rdn_left--;
                rdn_served++;
                if (rdn_served == rdn_vld_at) rdn_weights_vld = 1'b1;
            end
            if (dnn_mem_ready && dnn_left > 0) begin
                dnn_left--;
                dnn_served++;
                if (dnn_served == dnn_vld_at) dnn_weights_vld = 1'b1;
            end
            rdn_mem_req = (rdn_left > 0);
            dnn_mem_req = (dnn_left > 0);
        end
    end

    // Memory: answers a request after mem_delay extra cycles, one-cycle ready.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_rd_ready) begin
                mem_rd_ready = 1'b0;
                mem_rd_data  = {16{32'hDEAD_BEEF}};
                mem_wait     = 0;
            end else if (mem_rd_req) begin
                if (mem_wait >= mem_delay) begin
                    mem_rd_ready = 1'b1;
                    mem_rd_data  = beat_of(mem_rd_addr);
                    cap_addr     = mem_rd_addr;
                end else begin
                    mem_wait++;
                end
            end else begin
                mem_wait     = 0;
                mem_rd_data  = {16{32'hDEAD_BEEF}};
            end
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        logic [32:0]  e;
        logic         got_own;
        weight_beat_t exp_data;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                req_len  = 0;
            end else begin
                if (mem_rd_req) begin
                    req_cycles++;
                    req_len++;
                    if (prev_req) chk("addr_stable", mem_rd_addr, prev_addr);
                end else if (prev_req) begin
                    last_req_len = req_len;
                    req_len      = 0;
                end
                if (rdn_mem_ready || dnn_mem_ready) begin
                    got_own = dnn_mem_ready;
                    if (rdn_mem_ready && dnn_mem_ready) chk("one_owner", 2'b11, 2'b01);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {got_own, cap_addr}, 33'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_owner", got_own, e[32]);
                        chk("beat_addr", cap_addr, e[31:0]);
                        exp_data = beat_of(e[31:0]);
                        if (e[32]) shadow_dnn = exp_data;
                        else       shadow_rdn = exp_data;
                        chk("rdn_data", rdn_weight_data, shadow_rdn);
                        chk("dnn_data", dnn_weight_data, shadow_dnn);
                    end
                end
                prev_req  = mem_rd_req;
                prev_addr = mem_rd_addr;
            end
        end
    end

    // driver tasks
    task automatic clear_stim();
        start = 1'b0;
        rdn_left = 0; dnn_left = 0; rdn_served = 0; dnn_served = 0;
        rdn_vld_at = -1; dnn_vld_at = -1;
        rdn_weights_vld = 1'b0; dnn_weights_vld = 1'b0;
        exp_q.delete();
        shadow_rdn = '0; shadow_dnn = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_stim();
        repeat (2) @(negedge clk);
        chk("rst_req", mem_rd_req, 0);
        chk("rst_addr", mem_rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_kick", {rdn_load_weights, dnn_load_weights}, 0);
        chk("rst_ready", {rdn_mem_ready, dnn_mem_ready}, 0);
        chk("rst_rdn_data", rdn_weight_data, 0);
        chk("rst_dnn_data", dnn_weight_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [31:0] rb, input logic [31:0] db);
        @(negedge clk);
        rdn_base = rb;
        dnn_base = db;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("busy_in_done", busy, 1);
        chk("beats_left_at_done", exp_q.size(), 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_after_done", busy, 0);
        rdn_weights_vld = 1'b0;
        dnn_weights_vld = 1'b0;
    endtask

    initial begin
        // 1: RDN alone, three beats at base, +64, +128
        do_reset();
        a5_mode = 1'b0; mem_delay = 0;
        dnn_weights_vld = 1'b1;
        rdn_left = 3; rdn_vld_at = 3;
        exp_q.push_back({1'b0, 32'h0000_2000});
        exp_q.push_back({1'b0, 32'h0000_2040});
        exp_q.push_back({1'b0, 32'h0000_2080});
        pulse_start(32'h0000_2000, 32'h0000_9000);
        chk("t1_rdn_kick", rdn_load_weights, 1);
        chk("t1_dnn_kick", dnn_load_weights, 1);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_kick_pulse", {rdn_load_weights, dnn_load_weights}, 0);
        wait_done(200);
        chk("t1_rdn_beats", rdn_served, 3);

        // 2: both request continuously, grants alternate starting with RDN
        do_reset();
        rdn_left = 3; rdn_vld_at = 3;
        dnn_left = 3; dnn_vld_at = 3;
        exp_q.push_back({1'b0, 32'h0000_1000});
        exp_q.push_back({1'b1, 32'h0000_8000});
        exp_q.push_back({1'b0, 32'h0000_1040});
        exp_q.push_back({1'b1, 32'h0000_8040});
        exp_q.push_back({1'b0, 32'h0000_1080});
        exp_q.push_back({1'b1, 32'h0000_8080});
        pulse_start(32'h0000_1000, 32'h0000_8000);
        wait_done(300);

        // 3: slow memory, 0xA5 beat lands only in DNN
        a5_mode = 1'b1; mem_delay = 5;
        rdn_weights_vld = 1'b1;
        dnn_left = 1; dnn_served = 0; dnn_vld_at = 1;
        exp_q.push_back({1'b1, 32'h0004_0000});
        pulse_start(32'h0000_7000, 32'h0004_0000);
        wait_done(300);
        chk("t3_req_len", last_req_len, 6);
        chk("t3_dnn_a5", dnn_weight_data, {64{8'hA5}});
        chk("t3_rdn_kept", rdn_weight_data, {16{32'h0000_1080}});

        // 4: RDN flags valid after 2 beats but keeps requesting; DNN finishes alone
        a5_mode = 1'b0; mem_delay = 0;
        rdn_left = 100; rdn_served = 0; rdn_vld_at = 2;
        dnn_left = 4;   dnn_served = 0; dnn_vld_at = 4;
        exp_q.push_back({1'b0, 32'h0000_0100});
        exp_q.push_back({1'b1, 32'h0000_0200});
        exp_q.push_back({1'b0, 32'h0000_0140});
        exp_q.push_back({1'b1, 32'h0000_0240});
        exp_q.push_back({1'b1, 32'h0000_0280});
        exp_q.push_back({1'b1, 32'h0000_02C0});
        pulse_start(32'h0000_0100, 32'h0000_0200);
        wait_done(400);
        chk("t4_rdn_beats", rdn_served, 2);
        chk("t4_dnn_beats", dnn_served, 4);
        rdn_left = 0;
        @(negedge clk);

        // 5: start while busy is ignored; reset during MEM abandons the read
        mem_delay = 3;
        rdn_left = 2; rdn_served = 0; rdn_vld_at = -1;
        exp_q.push_back({1'b0, 32'h0000_3000});
        exp_q.push_back({1'b0, 32'h0000_3040});
        pulse_start(32'h0000_3000, 32'h0000_5000);
        chk("t5_kick", rdn_load_weights, 1);
        for (int n = 0; n < 100 && rdn_served < 1; n++) @(negedge clk);
        chk("t5_first_beat", rdn_served, 1);
        pulse_start(32'h0000_F000, 32'h0000_E000);
        chk("t5_busy_start_ignored", {rdn_load_weights, dnn_load_weights}, 0);
        chk("t5_busy", busy, 1);
        for (int n = 0; n < 100 && mem_rd_req !== 1'b1; n++) @(negedge clk);
        chk("t5_second_addr", mem_rd_addr, 32'h0000_3040);
        @(negedge clk);
        chk("t5_still_in_mem", mem_rd_req, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req", mem_rd_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rdn_data", rdn_weight_data, 0);
        do_reset();
        mem_delay = 0;

        // 6: both valid with both requests pending -> straight to done, no read
        rdn_left = 5; dnn_left = 5;
        rdn_weights_vld = 1'b1; dnn_weights_vld = 1'b1;
        req_cycles = 0;
        pulse_start(32'h0000_6000, 32'h0000_7000);
        chk("t6_kick", {rdn_load_weights, dnn_load_weights}, 2'b11);
        @(negedge clk);
        chk("t6_arb_no_done", done, 0);
        @(negedge clk);
        chk("t6_done", done, 1);
        chk("t6_busy_in_done", busy, 1);
        @(negedge clk);
        chk("t6_done_pulse", done, 0);
        chk("t6_busy_low", busy, 0);
        chk("t6_no_mem_req", req_cycles, 0);
        rdn_left = 0; dnn_left = 0;
        rdn_weights_vld = 1'b0; dnn_weights_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_stray_beats", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
